// File: rtl/urv_irq_ctrl.sv
// urv_irq_ctrl: machine-mode trap/interrupt controller with prioritised level-sensitive IRQs and optional vectored mtvec
module urv_irq_ctrl #(
    parameter int          NUM_IRQ     = 4,
    parameter int          VECTORED    = 1,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               x_stall_i,
    input  logic               x_kill_i,
    input  logic               d_is_csr_i,
    input  logic               d_is_mret_i,
    input  logic [11:0]        d_csr_sel_i,
    input  logic [31:0]        x_csr_write_value_i,
    input  logic               exp_tick_i,
    input  logic [NUM_IRQ-1:0] exp_irq_i,
    input  logic               x_exception_i,
    input  logic [3:0]         x_exception_cause_i,
    input  logic [31:0]        x_exception_pc_i,
    input  logic               x_irq_ack_i,
    output logic               irq_req_o,
    output logic [4:0]         irq_cause_o,
    output logic [31:0]        x_trap_target_o,
    output logic [31:0]        x_mret_pc_o,
    output logic [31:0]        csr_mstatus_o,
    output logic [31:0]        csr_mie_o,
    output logic [31:0]        csr_mip_o,
    output logic [31:0]        csr_mtvec_o,
    output logic [31:0]        csr_mepc_o,
    output logic [31:0]        csr_mcause_o
);
    localparam logic [31:0] MIE_MASK = 32'h80 | (((32'h1 << NUM_IRQ) - 32'h1) << 16);
    logic               r_mstatus_mie;
    logic               r_mstatus_mpie;
    logic [31:0]        r_mie;
    logic               r_tip;
    logic [NUM_IRQ-1:0] r_eip;
    logic [31:0]        r_mepc;
    logic [31:0]        r_mcause;
    logic [31:0]        r_mtvec;
    logic               w_csr_we;
    logic               w_mret;
    logic               w_take_irq;
    logic [31:0]        w_mip;
    logic [31:0]        w_active;
    logic [4:0]         w_cause;
    logic [31:0]        w_base;
    assign w_csr_we   = d_is_csr_i & ~x_stall_i & ~x_kill_i;
    assign w_mret     = d_is_mret_i & ~x_stall_i & ~x_kill_i;
    // a simultaneous exception pre-empts the interrupt, so the ack is not consumed
    assign w_take_irq = x_irq_ack_i & irq_req_o & ~x_exception_i;
    assign w_mip      = (32'(r_eip) << 16) | (32'(r_tip) << 7);
    assign w_active   = w_mip & r_mie;
    assign irq_req_o  = r_mstatus_mie & |w_active;
    always_comb begin
        w_cause = w_active[7] ? 5'd7 : 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (w_active[16+i]) w_cause = 5'(16 + i);
    end
    assign irq_cause_o     = irq_req_o ? w_cause : 5'd0;
    assign w_base          = {r_mtvec[31:2], 2'b00};
    assign x_trap_target_o = (r_mtvec[0] & irq_req_o) ? w_base + {25'd0, irq_cause_o, 2'b00} : w_base;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'd0;
            r_tip          <= 1'b0;
            r_eip          <= '0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_mtvec        <= RESET_MTVEC;
        end else begin
            r_eip <= exp_irq_i;
            r_tip <= exp_tick_i | (r_tip & ~((w_take_irq & (irq_cause_o == 5'd7)) |
                     (w_csr_we & (d_csr_sel_i == 12'h344) & ~x_csr_write_value_i[7])));
            if (x_exception_i || w_take_irq) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_mepc         <= {x_exception_pc_i[31:2], 2'b00};
                r_mcause       <= x_exception_i ? {28'd0, x_exception_cause_i} : {1'b1, 26'd0, irq_cause_o};
            end else if (w_mret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_csr_we) begin
                if (d_csr_sel_i == 12'h300) begin
                    r_mstatus_mie  <= x_csr_write_value_i[3];
                    r_mstatus_mpie <= x_csr_write_value_i[7];
                end
                if (d_csr_sel_i == 12'h341) r_mepc <= {x_csr_write_value_i[31:2], 2'b00};
                if (d_csr_sel_i == 12'h342) r_mcause <= x_csr_write_value_i;
            end
            if (w_csr_we && d_csr_sel_i == 12'h304) r_mie <= x_csr_write_value_i & MIE_MASK;
            if (w_csr_we && d_csr_sel_i == 12'h305)
                r_mtvec <= {x_csr_write_value_i[31:2], 1'b0, (VECTORED != 0) & x_csr_write_value_i[0]};
        end
    end
    assign x_mret_pc_o   = r_mepc;
    assign csr_mstatus_o = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
    assign csr_mie_o     = r_mie;
    assign csr_mip_o     = w_mip;
    assign csr_mtvec_o   = r_mtvec;
    assign csr_mepc_o    = r_mepc;
    assign csr_mcause_o  = r_mcause;
endmodule

// File: tb/tb_urv_irq_ctrl.sv
// tb_urv_irq_ctrl: directed vectors with hand-computed expectations for urv_irq_ctrl
module tb_urv_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x_stall = 1'b0, x_kill = 1'b0, d_is_csr = 1'b0, d_is_mret = 1'b0;
    logic [11:0] csr_sel = 12'd0;
    logic [31:0] csr_wv = 32'd0;
    logic        tick = 1'b0;
    logic [3:0]  irq = 4'd0;
    logic        exc = 1'b0;
    logic [3:0]  exc_cause = 4'd0;
    logic [31:0] pc = 32'd0;
    logic        ack = 1'b0;
    logic        req;
    logic [4:0]  cause;
    logic [31:0] target, mret_pc, mstatus, mie, mip, mtvec, mepc, mcause;
    logic        v0_req;
    logic [4:0]  v0_cause;
    logic [31:0] v0_target, v0_mret_pc, v0_mstatus, v0_mie, v0_mip, v0_mtvec, v0_mepc, v0_mcause;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    urv_irq_ctrl #(.NUM_IRQ(4), .VECTORED(1), .RESET_MTVEC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .d_is_csr_i(d_is_csr), .d_is_mret_i(d_is_mret), .d_csr_sel_i(csr_sel),
        .x_csr_write_value_i(csr_wv), .exp_tick_i(tick), .exp_irq_i(irq),
        .x_exception_i(exc), .x_exception_cause_i(exc_cause), .x_exception_pc_i(pc),
        .x_irq_ack_i(ack), .irq_req_o(req), .irq_cause_o(cause), .x_trap_target_o(target),
        .x_mret_pc_o(mret_pc), .csr_mstatus_o(mstatus), .csr_mie_o(mie), .csr_mip_o(mip),
        .csr_mtvec_o(mtvec), .csr_mepc_o(mepc), .csr_mcause_o(mcause));

    urv_irq_ctrl #(.NUM_IRQ(4), .VECTORED(0), .RESET_MTVEC(32'h0)) dut_v0 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .d_is_csr_i(d_is_csr), .d_is_mret_i(d_is_mret), .d_csr_sel_i(csr_sel),
        .x_csr_write_value_i(csr_wv), .exp_tick_i(tick), .exp_irq_i(irq),
        .x_exception_i(exc), .x_exception_cause_i(exc_cause), .x_exception_pc_i(pc),
        .x_irq_ack_i(ack), .irq_req_o(v0_req), .irq_cause_o(v0_cause), .x_trap_target_o(v0_target),
        .x_mret_pc_o(v0_mret_pc), .csr_mstatus_o(v0_mstatus), .csr_mie_o(v0_mie), .csr_mip_o(v0_mip),
        .csr_mtvec_o(v0_mtvec), .csr_mepc_o(v0_mepc), .csr_mcause_o(v0_mcause));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] v);
        d_is_csr = 1'b1;
        csr_sel = a;
        csr_wv = v;
        tick_clk();
        d_is_csr = 1'b0;
    endtask

    initial begin
        repeat (2) tick_clk();
        rst = 1'b0;
        chk("rst_mstatus", mstatus, 32'h0);
        chk("rst_mie", mie, 32'h0);
        chk("rst_mip", mip, 32'h0);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_mcause", mcause, 32'h0);
        chk("rst_mtvec", mtvec, 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_target", target, 32'h0);
        chk("rst_v0_outs", 32'(|{v0_req, v0_cause, v0_target, v0_mret_pc, v0_mstatus, v0_mie,
                                  v0_mip, v0_mtvec, v0_mepc, v0_mcause}), 32'h0);
        // single line, one-cycle latency, then ack
        csr_wr(12'h304, 32'h0001_0000);
        csr_wr(12'h300, 32'h8);
        irq = 4'b0001;
        #1 chk("irq0_lat0_req", 32'(req), 32'h0);
        tick_clk();
        chk("irq0_req", 32'(req), 32'h1);
        chk("irq0_cause", 32'(cause), 32'd16);
        ack = 1'b1;
        pc = 32'h100;
        #1 chk("irq0_target", target, 32'h0);
        tick_clk();
        ack = 1'b0;
        irq = 4'b0000;
        chk("irq0_mepc", mepc, 32'h100);
        chk("irq0_mcause", mcause, 32'h8000_0010);
        chk("irq0_mstatus", mstatus, 32'h80);
        chk("irq0_req_drop", 32'(req), 32'h0);
        // priority among lines and timer
        csr_wr(12'h304, 32'h000F_0080);
        csr_wr(12'h300, 32'h8);
        irq = 4'b0110;
        tick = 1'b1;
        tick_clk();
        tick = 1'b0;
        chk("prio_mip", mip, 32'h0006_0080);
        chk("prio_c17", 32'(cause), 32'd17);
        irq = 4'b0100;
        tick_clk();
        chk("prio_c18", 32'(cause), 32'd18);
        irq = 4'b0000;
        tick_clk();
        chk("prio_c7", 32'(cause), 32'd7);
        chk("prio_req7", 32'(req), 32'h1);
        ack = 1'b1;
        pc = 32'h200;
        tick_clk();
        ack = 1'b0;
        chk("tmr_mcause", mcause, 32'h8000_0007);
        chk("tmr_mip_clr", mip, 32'h0);
        chk("tmr_mepc", mepc, 32'h200);
        // vectored dispatch
        csr_wr(12'h305, 32'h0000_1001);
        chk("mtvec_v1", mtvec, 32'h0000_1001);
        chk("mtvec_v0", v0_mtvec, 32'h0000_1000);
        csr_wr(12'h300, 32'h8);
        irq = 4'b0100;
        tick_clk();
        chk("vec_cause", 32'(cause), 32'd18);
        chk("vec_target", target, 32'h0000_1048);
        chk("vec_target_v0", v0_target, 32'h0000_1000);
        ack = 1'b1;
        pc = 32'h300;
        tick_clk();
        ack = 1'b0;
        irq = 4'b0000;
        chk("vec_mcause", mcause, 32'h8000_0012);
        exc = 1'b1;
        exc_cause = 4'd2;
        pc = 32'h404;
        #1 chk("exc_target", target, 32'h0000_1000);
        tick_clk();
        exc = 1'b0;
        chk("exc_mcause", mcause, 32'h2);
        chk("exc_mepc", mepc, 32'h404);
        chk("exc_mstatus", mstatus, 32'h0);
        // trap then mret, and a killed/stalled mret
        csr_wr(12'h300, 32'h8);
        exc = 1'b1;
        exc_cause = 4'd3;
        pc = 32'h500;
        tick_clk();
        exc = 1'b0;
        chk("trap_mstatus", mstatus, 32'h80);
        d_is_mret = 1'b1;
        tick_clk();
        d_is_mret = 1'b0;
        chk("mret_mstatus", mstatus, 32'h88);
        chk("mret_pc", mret_pc, 32'h500);
        csr_wr(12'h300, 32'h0);
        x_kill = 1'b1;
        d_is_mret = 1'b1;
        tick_clk();
        x_kill = 1'b0;
        x_stall = 1'b1;
        tick_clk();
        x_stall = 1'b0;
        d_is_mret = 1'b0;
        chk("mret_kill", mstatus, 32'h0);
        // exception beats a simultaneous ack; tick survives
        csr_wr(12'h300, 32'h8);
        tick = 1'b1;
        tick_clk();
        tick = 1'b0;
        chk("both_req", 32'(req), 32'h1);
        exc = 1'b1;
        exc_cause = 4'd5;
        pc = 32'h600;
        ack = 1'b1;
        tick_clk();
        exc = 1'b0;
        ack = 1'b0;
        chk("both_mcause", mcause, 32'h5);
        chk("both_mip", mip, 32'h80);
        chk("both_mstatus", mstatus, 32'h80);
        // mip clear write vs tick
        csr_wr(12'h344, 32'h0);
        chk("mip_clr", mip, 32'h0);
        tick = 1'b1;
        d_is_csr = 1'b1;
        csr_sel = 12'h344;
        csr_wv = 32'h0;
        tick_clk();
        tick = 1'b0;
        d_is_csr = 1'b0;
        chk("mip_set_wins", mip, 32'h80);
        csr_wr(12'h304, 32'hFFFF_FFFF);
        chk("mie_mask", mie, 32'h000F_0080);
        csr_wr(12'h341, 32'h0000_0123);
        chk("mepc_align", mepc, 32'h120);
        // reset mid-operation
        csr_wr(12'h300, 32'h8);
        chk("pre_rst_req", 32'(req), 32'h1);
        rst = 1'b1;
        tick_clk();
        rst = 1'b0;
        chk("mrst_mstatus", mstatus, 32'h0);
        chk("mrst_mip", mip, 32'h0);
        chk("mrst_mie", mie, 32'h0);
        chk("mrst_mtvec", mtvec, 32'h0);
        chk("mrst_req", 32'(req), 32'h0);
        chk("mrst_cause", 32'(cause), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
